// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register chain.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH  = 4;
  localparam int PIPE_DATA_WIDTH = 96;
  localparam int PIPE_CTRL_WIDTH = 4;
  localparam int STAT_W          = 32;

  // Memory-stage control bundle carried by the execute->memory instance.
  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
  } ctrl_m_t;

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline slot: valid bit, control bundle and payload.
// Control is zeroed whenever the slot becomes invalid so that downstream
// write enables read low during bubbles; payload is a don't-care then.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  in_v,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  v,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  // Slot state: reset clears everything, clear kills v/ctrl only, load advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v    <= 1'b0;
      ctrl <= '0;
      data <= '0;
    end else if (clear) begin
      v    <= 1'b0;
      ctrl <= '0;
    end else if (load) begin
      v    <= in_v;
      ctrl <= in_v ? in_ctrl : '0;
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-deep elastic register chain between two CPU pipeline stages, with
// backpressure, hazard stall, flush and bubble squashing.
// Optional feature macro: PIPE_STATS_EN (saturating statistics counters).
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_count,
  output logic [31:0]                  bubble_cycles
);

  localparam int OCC_W = $clog2(DEPTH+1);

  generate
    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
      $error("pipe_stage_elastic: DEPTH must be within 1..%0d", PIPE_MAX_DEPTH);
    end
  endgenerate

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      adv;
  logic [DEPTH-1:0]      src_v;
  logic [CTRL_WIDTH-1:0] ctrl_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  logic [CTRL_WIDTH-1:0] src_ctrl [DEPTH];
  logic [DATA_WIDTH-1:0] src_data [DEPTH];
  logic                  accept;
  logic [OCC_W-1:0]      occ_nxt;

  // Advance chain from the output side back to the input; frozen by stall/flush.
  always_comb begin
    adv = '0;
    if (!stall_i && !flush_i) begin
      adv[DEPTH-1] = !v[DEPTH-1] || out_ready;
      for (int k = DEPTH-2; k >= 0; k--) begin
        adv[k] = !v[k] || adv[k+1];
      end
    end
  end

  assign in_ready = adv[0];
  assign accept   = in_valid && in_ready;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      if (k == 0) begin : g_src_in
        assign src_v[k]    = accept;
        assign src_ctrl[k] = in_ctrl;
        assign src_data[k] = in_data;
      end else begin : g_src_prev
        assign src_v[k]    = v[k-1];
        assign src_ctrl[k] = ctrl_q[k-1];
        assign src_data[k] = data_q[k-1];
      end

      pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush_i),
        .load    (adv[k]),
        .in_v    (src_v[k]),
        .in_ctrl (src_ctrl[k]),
        .in_data (src_data[k]),
        .v       (v[k]),
        .ctrl    (ctrl_q[k]),
        .data    (data_q[k])
      );
    end
  endgenerate

  assign out_valid = v[DEPTH-1] && !stall_i;
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Popcount of the valid bits the slots will hold after this edge.
  always_comb begin
    occ_nxt = '0;
    if (!flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k] ? src_v[k] : v[k]) begin
          occ_nxt = occ_nxt + OCC_W'(1);
        end
      end
    end
  end

  // Registered occupancy, updated on the same edge as the valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

`ifdef PIPE_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] flush_q;
  logic [STAT_W-1:0] bubble_q;

  // Saturating statistics; flush does not clear them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_i)                    stall_q  <= sat_inc(stall_q);
      if (flush_i)                    flush_q  <= sat_inc(flush_q);
      if (!v[DEPTH-1] && !stall_i)    bubble_q <= sat_inc(bubble_q);
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign bubble_cycles = bubble_q;
`else
  assign stall_cycles  = '0;
  assign flush_count   = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic (DEPTH=2): stimulus pushes the
// expected output entries, a negedge monitor pops and compares transfers.
module tb_pipe_stage_elastic;

  localparam int DW = 96;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, stall_i, flush_i, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [31:0]   stall_cycles, flush_count, bubble_cycles;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pipe_stage_elastic #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .bubble_cycles (bubble_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for one edge; push it as expected only if it should be taken.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic exp_rdy);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    #1;
    check("in_ready", in_ready, exp_rdy);
    if (exp_rdy) sb.push_back('{c: c, d: d});
    step();
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
  endtask

  // Monitor: every transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_ctrl", out_ctrl, e.c);
        check("out_data", out_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    // Reset state
    check("rst_occ", occupancy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_flush", flush_count, 0);
    check("rst_bubble", bubble_cycles, 0);
    step(); step();
`ifdef PIPE_STATS_EN
    check("bubble_idle", bubble_cycles, 2);
`else
    check("bubble_idle", bubble_cycles, 0);
`endif

    // Streaming 1..5 with out_ready high
    out_ready = 1'b1;
    send(4'hF, 96'd1, 1'b1);
    check("lat_first_edge", out_valid, 0);
    send(4'hF, 96'd2, 1'b1);
    check("lat_second_edge", out_valid, 1);
    check("lat_first_data", out_data, 1);
    send(4'hF, 96'd3, 1'b1);
    check("stream_occ", occupancy, 2);
    send(4'hF, 96'd4, 1'b1);
    send(4'hF, 96'd5, 1'b1);
    check("stream_occ2", occupancy, 2);
    step(); step(); step();
    check("stream_drained", sb.size(), 0);
    check("stream_empty_occ", occupancy, 0);

    // Backpressure: fill with A,B then block
    out_ready = 1'b0;
    send(4'h9, 96'hAAAA_0000_0000_0000_0000_000A, 1'b1);
    send(4'h6, 96'hBBBB_0000_0000_0000_0000_000B, 1'b1);
    check("bp_occ", occupancy, 2);
    send(4'h3, 96'hCCCC, 1'b0);
    step();
    check("bp_hold_data", out_data, 96'hAAAA_0000_0000_0000_0000_000A);
    check("bp_hold_valid", out_valid, 1);
    check("bp_occ_hold", occupancy, 2);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", in_ready, 1);
    step(); step(); step();
    check("bp_drained", sb.size(), 0);
    check("bp_empty_occ", occupancy, 0);

    // Bubble squash: 1,0,1 with output blocked
    out_ready = 1'b0;
    send(4'h5, 96'hD1, 1'b1);
    check("sq_bubble_ctrl", out_ctrl, 0);
    check("sq_occ1", occupancy, 1);
    step();
    check("sq_out_d", out_data, 96'hD1);
    check("sq_out_ctrl", out_ctrl, 4'h5);
    send(4'hA, 96'hE2, 1'b1);
    check("sq_occ2", occupancy, 2);
    #1;
    check("sq_full_rdy", in_ready, 0);
    out_ready = 1'b1;
    step(); step(); step();
    check("sq_drained", sb.size(), 0);

    // Flush with stall and in_valid at the same edge
    out_ready = 1'b0;
    send(4'h7, 96'hF0, 1'b1);
    send(4'hB, 96'hF1, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    send(4'hC, 96'hF2, 1'b0);
    stall_i = 1'b0; flush_i = 1'b0;
    sb.delete();
    #1;
    check("fl_occ", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    check("fl_data_hold", out_data, 96'hF0);
    check("fl_in_ready", in_ready, 1);
`ifdef PIPE_STATS_EN
    check("fl_count", flush_count, 1);
`else
    check("fl_count", flush_count, 0);
`endif

    // Stall three cycles with a full chain and out_ready high
    send(4'h1, 96'h111, 1'b1);
    send(4'h2, 96'h222, 1'b1);
    stall_i = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_out_valid", out_valid, 0);
      check("st_in_ready", in_ready, 0);
      step();
      check("st_occ", occupancy, 2);
    end
    check("st_data_hold", out_data, 96'h111);
    stall_i = 1'b0;
    #1;
`ifdef PIPE_STATS_EN
    check("st_count", stall_cycles, 4);
`else
    check("st_count", stall_cycles, 0);
`endif
    step(); step(); step();
    check("st_drained", sb.size(), 0);

    // Reset mid-stream with two entries held
    out_ready = 1'b0;
    send(4'h4, 96'h444, 1'b1);
    send(4'h8, 96'h888, 1'b1);
    check("mr_occ_before", occupancy, 2);
    rst_n = 1'b0;
    step();
    sb.delete();
    check("mr_occ", occupancy, 0);
    check("mr_out_data", out_data, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_stall", stall_cycles, 0);
    check("mr_flush", flush_count, 0);
    check("mr_bubble", bubble_cycles, 0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
